// File: rtl/queue_fifo_pkg.sv
// Shared constants for the operand queue in front of the adder/subtractor datapath.
package queue_fifo_pkg;
  localparam int DATA_W = 10;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;
  localparam int CNT_W  = ADDR_W + 1;

  localparam logic [DATA_W-1:0] POP_DATA_RST = '0;
endpackage

// File: rtl/queue_fifo_fas.sv
// N-bit adder/subtractor: s = a + b when d = 0, s = a - b when d = 1.
module queue_fifo_fas #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         d,
  output logic [N-1:0] s,
  output logic         co
);
  logic [N:0] c;

  assign c[0] = d;

  // Two's-complement subtract: invert b and inject d as carry-in.
  for (genvar i = 0; i < N; i++) begin : g_bit
    logic bx;
    assign bx     = b[i] ^ d;
    assign s[i]   = a[i] ^ bx ^ c[i];
    assign c[i+1] = (a[i] & bx) | (a[i] & c[i]) | (bx & c[i]);
  end

  assign co = c[N];
endmodule

// File: rtl/queue_fifo.sv
// 8-entry operand FIFO with registered read data, full/empty and sticky ovf/udf debug flags.
module queue_fifo #(
  parameter int DATA_W = queue_fifo_pkg::DATA_W,
  parameter int DEPTH  = queue_fifo_pkg::DEPTH,
  parameter int ADDR_W = queue_fifo_pkg::ADDR_W,
  parameter int CNT_W  = queue_fifo_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_valid,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count,
  output logic              ovf,
  output logic              udf
);
  import queue_fifo_pkg::*;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              push_acc, pop_acc;
  logic [CNT_W-1:0]  cnt_s, cnt_nxt;
  logic              cnt_co_unused;

  assign push_acc = push & ~full;
  assign pop_acc  = pop  & ~empty;

  queue_fifo_fas #(.N(CNT_W)) u_cnt (
    .a  (count),
    .b  (CNT_W'(1)),
    .d  (pop_acc & ~push_acc),
    .s  (cnt_s),
    .co (cnt_co_unused)
  );

  // Simultaneous accepted push and pop leaves occupancy unchanged.
  assign cnt_nxt = (push_acc ^ pop_acc) ? cnt_s : count;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      ovf       <= 1'b0;
      udf       <= 1'b0;
      pop_valid <= 1'b0;
      pop_data  <= DATA_W'(POP_DATA_RST);
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop_acc) begin
        rd_ptr   <= rd_ptr + 1'b1;
        pop_data <= mem[rd_ptr];
      end
      pop_valid <= pop_acc;
      count     <= cnt_nxt;
      full      <= (cnt_nxt == CNT_W'(DEPTH));
      empty     <= (cnt_nxt == '0);
      if (push & full)  ovf <= 1'b1;
      if (pop  & empty) udf <= 1'b1;
    end
  end

  // Storage is deliberately not reset; the pointers make stale words unreachable.
  always_ff @(posedge clk) begin
    if (!rst && push_acc) mem[wr_ptr] <= push_data;
  end
endmodule

// File: tb/tb_queue_fifo.sv
// Directed and randomized check of queue_fifo against a queue-based reference model.
module tb_queue_fifo;
  localparam int DATA_W = 10;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst, push, pop;
  logic [DATA_W-1:0] push_data;
  logic [DATA_W-1:0] pop_data;
  logic              pop_valid, full, empty, ovf, udf;
  logic [CNT_W-1:0]  count;

  int vecs = 0;
  int errs = 0;

  logic [DATA_W-1:0] q [$];
  logic [DATA_W-1:0] m_pd;
  logic              m_pv, m_ovf, m_udf;

  always #5 clk = ~clk;

  queue_fifo dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .pop_valid (pop_valid),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .ovf       (ovf),
    .udf       (udf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("count",     32'(count),     32'(q.size()));
    chk("full",      32'(full),      32'(q.size() == DEPTH));
    chk("empty",     32'(empty),     32'(q.size() == 0));
    chk("pop_valid", 32'(pop_valid), 32'(m_pv));
    chk("pop_data",  32'(pop_data),  32'(m_pd));
    chk("ovf",       32'(ovf),       32'(m_ovf));
    chk("udf",       32'(udf),       32'(m_udf));
  endtask

  // One clock: drive inputs, advance the model by the queue rules, then compare.
  task automatic step(input logic r, input logic pu, input logic [DATA_W-1:0] d, input logic po);
    bit pa, oa;
    rst = r; push = pu; push_data = d; pop = po;
    @(posedge clk);
    if (r) begin
      q.delete();
      m_pd = '0; m_pv = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      pa = pu && (q.size() < DEPTH);
      oa = po && (q.size() > 0);
      if (pu && !pa) m_ovf = 1'b1;
      if (po && !oa) m_udf = 1'b1;
      m_pv = oa;
      if (oa) m_pd = q.pop_front();
      if (pa) q.push_back(d);
    end
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b1; push = 1'b0; pop = 1'b0; push_data = '0;
    m_pd = '0; m_pv = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;

    step(1, 0, 0, 0);
    step(1, 1, 10'h155, 1);
    step(0, 0, 0, 0);

    // Fill, overflow, drain, underflow.
    for (int i = 1; i <= 8; i++) step(0, 1, DATA_W'(i), 0);
    chk("full_after_fill", 32'(full), 32'd1);
    step(0, 1, 10'h3FF, 0);
    chk("ovf_on_full_push", 32'(ovf), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      step(0, 0, 0, 1);
      chk("drain_order", 32'(pop_data), 32'(i));
    end
    step(0, 0, 0, 1);
    chk("udf_on_empty_pop", 32'(udf), 32'd1);
    chk("pop_data_hold",    32'(pop_data), 32'h008);

    // Pointer wrap-around.
    step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, DATA_W'(10'h050 + i), 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
    for (int i = 0; i < 6; i++) step(0, 1, DATA_W'(10'h100 + i), 0);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 1);
      chk("wrap_order", 32'(pop_data), 32'(10'h100 + i));
    end

    // Simultaneous push+pop at count 3.
    for (int i = 0; i < 3; i++) step(0, 1, DATA_W'(10'h200 + i), 0);
    step(0, 1, 10'h2AA, 1);
    chk("pp_mid_count", 32'(count), 32'd3);

    // Simultaneous push+pop at full: pop accepted, push rejected.
    for (int i = 0; i < 5; i++) step(0, 1, DATA_W'(10'h300 + i), 0);
    step(0, 1, 10'h3EE, 1);
    chk("pp_full_count", 32'(count), 32'd7);
    chk("pp_full_ovf",   32'(ovf),   32'd1);

    // Reset mid-operation at count 5.
    step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, DATA_W'(i + 7), 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 1, DATA_W'(i + 20), 0);
    step(1, 1, 10'h111, 1);
    chk("rst_mid_count", 32'(count), 32'd0);
    chk("rst_mid_empty", 32'(empty), 32'd1);

    // Randomized traffic with drifting push/pop bias and rare resets.
    for (int n = 0; n < 3000; n++) begin
      int bias;
      bias = (n / 150) % 3;
      step(($urandom_range(0, 249) == 0),
           ($urandom_range(0, 9) < (bias == 0 ? 8 : (bias == 1 ? 2 : 5))),
           DATA_W'($urandom),
           ($urandom_range(0, 9) < (bias == 0 ? 2 : (bias == 1 ? 8 : 5))));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
